// File: rtl/aeolus_display_pkg.sv
// Shared types and constants for the CPU output display driver.
// Segment codes are {g,f,e,d,c,b,a}, active-low.
package aeolus_display_pkg;

   localparam int BCD_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } conv_state_e;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0     = 7'b1000000;
   localparam seg_t SEG_1     = 7'b1111001;
   localparam seg_t SEG_2     = 7'b0100100;
   localparam seg_t SEG_3     = 7'b0110000;
   localparam seg_t SEG_4     = 7'b0011001;
   localparam seg_t SEG_5     = 7'b0010010;
   localparam seg_t SEG_6     = 7'b0000010;
   localparam seg_t SEG_7     = 7'b1111000;
   localparam seg_t SEG_8     = 7'b0000000;
   localparam seg_t SEG_9     = 7'b0010000;
   localparam seg_t SEG_MINUS = 7'b0111111;
   localparam seg_t SEG_BLANK = 7'b1111111;

   function automatic seg_t seg_of(input logic [BCD_W-1:0] d);
      unique case (d)
         4'd0:    seg_of = SEG_0;
         4'd1:    seg_of = SEG_1;
         4'd2:    seg_of = SEG_2;
         4'd3:    seg_of = SEG_3;
         4'd4:    seg_of = SEG_4;
         4'd5:    seg_of = SEG_5;
         4'd6:    seg_of = SEG_6;
         4'd7:    seg_of = SEG_7;
         4'd8:    seg_of = SEG_8;
         4'd9:    seg_of = SEG_9;
         default: seg_of = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble converter: one operand bit per cycle,
// eight SHIFT cycles then a COMMIT cycle that publishes the result.
module bin_to_bcd_serial
   import aeolus_display_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  operand,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd,
   output logic [11:0] result
);

   conv_state_e state;
   logic [7:0]  sh;
   logic [2:0]  count;

   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] n);
      add3 = (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   // Hundreds never reaches 5 for an 8-bit operand, so it only shifts.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         sh     <= '0;
         bcd    <= '0;
         count  <= '0;
         result <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sh    <= operand;
                  bcd   <= '0;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               bcd <= {bcd[10:8], add3(bcd[7:4]), add3(bcd[3:0]), sh[7]};
               sh  <= {sh[6:0], 1'b0};
               if (count == 3'd7) begin
                  done  <= 1'b1;
                  state <= COMMIT;
               end else begin
                  count <= count + 3'd1;
               end
            end
            COMMIT: begin
               result <= bcd;
               busy   <= 1'b0;
               done   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/aeolus_display_driver.sv
// Shows the CPU output register in decimal on a 4-digit multiplexed
// seven-segment display, optionally as a signed value.
module aeolus_display_driver
   import aeolus_display_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                  boardCLK,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] valueIn,
   input  logic                  signedMode,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [3:0]            an,
   output logic                  busy,
   output logic [11:0]           bcdOut
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [DATA_WIDTH-1:0] last_value;
   logic                  last_mode;
   logic                  pending;
   logic                  neg_pend;
   logic                  neg_in;
   logic [DATA_WIDTH-1:0] magnitude;
   logic                  start;
   logic                  done;
   logic [11:0]           bcd_live;
   logic [BCD_W-1:0]      hund, tens, ones;
   seg_t                  disp [4];
   logic [1:0]            idx;
   logic [CNT_W-1:0]      rcnt;

   assign dp = 1'b1;

   assign neg_in    = signedMode & valueIn[DATA_WIDTH-1];
   assign magnitude = neg_in ? (~valueIn + 1'b1) : valueIn;

   // Changes arriving mid-conversion are caught here on the next idle cycle.
   assign start = ~busy & (pending
                  | (valueIn != last_value)
                  | (signedMode != last_mode));

   assign hund = bcd_live[11:8];
   assign tens = bcd_live[7:4];
   assign ones = bcd_live[3:0];

   bin_to_bcd_serial u_conv (
      .clk     (boardCLK),
      .reset   (reset),
      .start   (start),
      .operand (magnitude),
      .busy    (busy),
      .done    (done),
      .bcd     (bcd_live),
      .result  (bcdOut)
   );

   always_ff @(posedge boardCLK) begin
      if (reset) begin
         last_value <= '0;
         last_mode  <= 1'b0;
         pending    <= 1'b1;
         neg_pend   <= 1'b0;
      end else if (start) begin
         last_value <= valueIn;
         last_mode  <= signedMode;
         pending    <= 1'b0;
         neg_pend   <= neg_in;
      end
   end

   // Digit codes change only at commit, so the old value stays lit meanwhile.
   always_ff @(posedge boardCLK) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) disp[i] <= SEG_BLANK;
      end else if (done) begin
         disp[3] <= neg_pend ? SEG_MINUS : SEG_BLANK;
         disp[2] <= (hund == '0) ? SEG_BLANK : seg_of(hund);
         disp[1] <= (hund == '0 && tens == '0) ? SEG_BLANK : seg_of(tens);
         disp[0] <= seg_of(ones);
      end
   end

   always_ff @(posedge boardCLK) begin
      if (reset) begin
         rcnt <= '0;
         idx  <= '0;
         seg  <= SEG_BLANK;
         an   <= 4'hF;
      end else begin
         if (rcnt == CNT_LAST) begin
            rcnt <= '0;
            idx  <= idx + 2'd1;
         end else begin
            rcnt <= rcnt + 1'b1;
         end
         an  <= ~(4'b0001 << idx);
         seg <= disp[idx];
      end
   end

endmodule

// File: tb/tb_aeolus_display_driver.sv
// Directed bench for the display driver with a 4-cycle refresh period.
// Conversions, sign handling, blanking, back-to-back updates and scanning.
module tb_aeolus_display_driver;

   logic        boardCLK = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  valueIn = 8'h00;
   logic        signedMode = 1'b0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        busy;
   logic [11:0] bcdOut;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [6:0] S_BL = 7'b1111111;
   localparam logic [6:0] S_MI = 7'b0111111;
   localparam logic [6:0] S_0  = 7'b1000000;
   localparam logic [6:0] S_1  = 7'b1111001;
   localparam logic [6:0] S_2  = 7'b0100100;
   localparam logic [6:0] S_4  = 7'b0011001;
   localparam logic [6:0] S_5  = 7'b0010010;
   localparam logic [6:0] S_7  = 7'b1111000;
   localparam logic [6:0] S_8  = 7'b0000000;

   aeolus_display_driver #(.REFRESH_DIV(4), .DATA_WIDTH(8)) dut (
      .boardCLK   (boardCLK),
      .reset      (reset),
      .valueIn    (valueIn),
      .signedMode (signedMode),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .busy       (busy),
      .bcdOut     (bcdOut)
   );

   always #5 boardCLK = ~boardCLK;

   // Drive a new input and check busy over cycles 1..9 and the commit.
   task automatic convert(input logic [7:0] v, input logic m,
                          input logic [11:0] exp, input string name);
      int bad;
      bad = 0;
      @(negedge boardCLK);
      valueIn = v;
      signedMode = m;
      for (int k = 1; k <= 9; k++) begin
         @(negedge boardCLK);
         if (busy !== 1'b1) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL %s busy_window: %0d low cycles, required 0", name, bad);
      end
      @(negedge boardCLK);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s busy_end: got %b, required 0", name, busy);
      end
      vectors++;
      if (bcdOut !== exp) begin
         miscompares++;
         $display("FAIL %s bcdOut: got %h, required %h", name, bcdOut, exp);
      end
   endtask

   // Watch a full scan period and check the segments shown on each digit.
   task automatic scan_digits(input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0,
                              input string name);
      logic [6:0] cap [4];
      logic [6:0] exp [4];
      exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
      for (int d = 0; d < 4; d++) cap[d] = 7'bx;
      @(negedge boardCLK);
      for (int k = 0; k < 16; k++) begin
         @(negedge boardCLK);
         case (an)
            4'b1110: cap[0] = seg;
            4'b1101: cap[1] = seg;
            4'b1011: cap[2] = seg;
            4'b0111: cap[3] = seg;
            default: ;
         endcase
      end
      for (int d = 0; d < 4; d++) begin
         vectors++;
         if (cap[d] !== exp[d]) begin
            miscompares++;
            $display("FAIL %s digit%0d: got %b, required %b",
                     name, d, cap[d], exp[d]);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge boardCLK);
      vectors++;
      if (seg !== 7'h7F || an !== 4'hF || dp !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_disp: got seg=%b an=%b dp=%b, required 1111111 1111 1",
                  seg, an, dp);
      end
      vectors++;
      if (busy !== 1'b0 || bcdOut !== 12'h000) begin
         miscompares++;
         $display("FAIL reset_conv: got busy=%b bcd=%h, required 0 000", busy, bcdOut);
      end
      reset = 1'b0;
      @(negedge boardCLK);
      vectors++;
      if (an !== 4'b1110 || seg !== S_BL) begin
         miscompares++;
         $display("FAIL first_cycle: got an=%b seg=%b, required 1110 1111111", an, seg);
      end
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL forced_conv: got busy=%b, required 1", busy);
      end
      repeat (9) @(negedge boardCLK);
      vectors++;
      if (busy !== 1'b0 || bcdOut !== 12'h000) begin
         miscompares++;
         $display("FAIL reset_commit: got busy=%b bcd=%h, required 0 000", busy, bcdOut);
      end
      scan_digits(S_BL, S_BL, S_BL, S_0, "zero");
   endtask

   task automatic test_unsigned();
      convert(8'hFF, 1'b0, 12'h255, "u255");
      scan_digits(S_BL, S_2, S_5, S_5, "u255");
   endtask

   task automatic test_signed();
      convert(8'hF6, 1'b1, 12'h010, "sF6");
      scan_digits(S_MI, S_BL, S_1, S_0, "sF6");
   endtask

   task automatic test_min_and_mode();
      convert(8'h80, 1'b1, 12'h128, "s80");
      scan_digits(S_MI, S_1, S_2, S_8, "s80");
      convert(8'h80, 1'b0, 12'h128, "u80");
      scan_digits(S_BL, S_1, S_2, S_8, "u80");
   endtask

   task automatic test_back_to_back();
      int flick;
      flick = 0;
      @(negedge boardCLK);
      valueIn = 8'd7;
      signedMode = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge boardCLK);
         if (k == 3) valueIn = 8'd42;
         if (k == 9) begin
            vectors++;
            if (bcdOut !== 12'h128) begin
               miscompares++;
               $display("FAIL b2b_hold: got %h, required 128", bcdOut);
            end
         end
         if (k == 10) begin
            vectors++;
            if (bcdOut !== 12'h007 || busy !== 1'b0) begin
               miscompares++;
               $display("FAIL b2b_first: got bcd=%h busy=%b, required 007 0",
                        bcdOut, busy);
            end
         end
         if (k == 11) begin
            vectors++;
            if (busy !== 1'b1) begin
               miscompares++;
               $display("FAIL b2b_restart: got busy=%b, required 1", busy);
            end
         end
         if (k >= 11 && k <= 19) begin
            if (seg !== ((an == 4'b1110) ? S_7 : S_BL)) flick++;
         end
         if (k == 19) begin
            vectors++;
            if (bcdOut !== 12'h007) begin
               miscompares++;
               $display("FAIL b2b_early: got %h, required 007", bcdOut);
            end
         end
         if (k == 20) begin
            vectors++;
            if (bcdOut !== 12'h042 || busy !== 1'b0) begin
               miscompares++;
               $display("FAIL b2b_second: got bcd=%h busy=%b, required 042 0",
                        bcdOut, busy);
            end
         end
      end
      vectors++;
      if (flick != 0) begin
         miscompares++;
         $display("FAIL b2b_display: %0d wrong samples, required 0", flick);
      end
      scan_digits(S_BL, S_BL, S_4, S_2, "d42");
   endtask

   task automatic test_scan_reset();
      logic [3:0] pat [5];
      int bad;
      pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011;
      pat[3] = 4'b0111; pat[4] = 4'b1110;
      bad = 0;
      @(negedge boardCLK);
      valueIn = 8'd99;
      repeat (4) @(negedge boardCLK);
      reset = 1'b1;
      @(negedge boardCLK);
      vectors++;
      if (an !== 4'hF || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset: got an=%b busy=%b, required 1111 0", an, busy);
      end
      vectors++;
      if (seg !== 7'h7F || bcdOut !== 12'h000) begin
         miscompares++;
         $display("FAIL midreset_out: got seg=%b bcd=%h, required 1111111 000",
                  seg, bcdOut);
      end
      @(negedge boardCLK);
      reset = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge boardCLK);
         if (an !== pat[(k - 1) / 4]) bad++;
         if (k == 10) begin
            vectors++;
            if (bcdOut !== 12'h099) begin
               miscompares++;
               $display("FAIL post_reset_conv: got %h, required 099", bcdOut);
            end
         end
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL an_sequence: %0d wrong samples, required 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_min_and_mode();
      test_back_to_back();
      test_scan_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/aeolus_display_driver.md
Name: aeolus_display_driver

Overview:
Downstream consumer of the CPU's 8-bit output register.
- Converts the output value to decimal with a serial double-dabble engine.
- Drives the board's 4-digit multiplexed seven-segment display, with optional two's-complement sign display.
- Runs on the undivided board clock, next to the CPU top, and takes cpuOut directly.

Parameters:
REFRESH_DIV, 100000, boardCLK cycles each digit is lit (use 4 in simulation)
DATA_WIDTH, 8, width of valueIn (fixed at 8; BCD result is 3 digits)

Ports:
boardCLK  input  1  board clock; the only clock
reset  input  1  synchronous, active-high reset
valueIn  input  8  value to display (cpuOut)
signedMode  input  1  1 = interpret valueIn as two's complement
seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
dp  output  1  decimal point, active-low; held 1 (off)
an  output  4  digit anodes, active-low one-hot, registered; an[0] = rightmost digit
busy  output  1  high while a conversion is in progress
bcdOut  output  12  committed BCD magnitude {hundreds,tens,ones}

Behaviour:
- One clock, boardCLK. Reset is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - seg=7'h7F, an=4'hF, dp=1, busy=0, bcdOut=0.
  - Committed digits are all blank; negative flag = 0; scan index = 0; refresh counter = 0.
  - pending = 1, so a conversion is forced after reset.
- Converter FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: a conversion starts if valueIn != lastValue, or signedMode != lastMode, or pending.
    - On start: latch lastValue, lastMode and the operand; clear pending; busy=1; count=0; go to SHIFT.
  - Operand: if signedMode and valueIn[7]=1, operand = (~valueIn + 1) as a 9-bit value and neg=1; otherwise operand = valueIn and neg=0. 0x80 gives 128.
  - SHIFT: one bit per cycle. Add 3 to each BCD nibble >= 5, then shift left by one, bringing in the operand MSB. After 8 shifts go to COMMIT.
  - COMMIT:
    - Load bcdOut and the neg flag.
    - Compute blanking:
      - hundreds blank if 0;
      - tens blank if hundreds=0 and tens=0;
      - ones never blank;
      - digit3 shows minus if neg, otherwise blank.
    - Set busy=0 and go to IDLE.
- Latency: input change sampled in cycle 0 → SHIFT in cycles 1–8 → COMMIT in cycle 9. bcdOut updates at the end of cycle 9. busy is high in cycles 1–9.
- Input changes during SHIFT or COMMIT are ignored. They are picked up in the next IDLE cycle by comparison against the latched value; no value is lost and the last stable value always wins.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the scan index advances 0→1→2→3→0.
  - Each cycle: an = ~(1<<index) and seg = encoding of the committed digit[index], both registered.
- Segment codes (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - minus=0111111, blank=1111111
- Reset asserted at any time, including mid-conversion or mid-scan, aborts all activity and returns every output to its reset value on the next edge. The first cycle after reset release shows an=1110 with seg=blank.
- The display keeps showing the previous committed value during a conversion; there is no flicker to blank.

Decomposition:
- Package aeolus_display_pkg:
  - converter state enum {IDLE, SHIFT, COMMIT};
  - segment code constants SEG_0..SEG_9, SEG_MINUS, SEG_BLANK;
  - BCD digit width constant (4).
- Sub-module bin_to_bcd_serial: holds the converter FSM and shift/add-3 datapath, with start/busy/done handshake and a 12-bit result.
- The top level holds change detection, sign handling, blanking, and the scan counter/mux.

Test Plan:
1. Reset with valueIn=0, unsigned; REFRESH_DIV=4.
   → bcdOut=12'h000 at cycle 9. Digit0 seg=1000000; digits 1–3 blank.
2. valueIn 0→255, unsigned.
   → busy high for exactly cycles 1–9. bcdOut=12'h255 at the end of cycle 9. Scanned segs: blank, 0100100, 0010010, 0010010.
3. signedMode=1, valueIn=8'hF6.
   → bcdOut=12'h010. Digit3 = minus, digit2 blank, digit1 = 1111001, digit0 = 1000000.
4. signedMode=1, valueIn=8'h80.
   → bcdOut=12'h128 with minus. Toggling signedMode to 0 alone triggers a reconversion with no minus: bcdOut=12'h128, digit3 blank.
5. valueIn=7, then valueIn=42 during cycle 3 of that conversion.
   → first commit bcdOut=12'h007. A second conversion starts automatically and commits 12'h042 ten cycles after returning to IDLE.
6. REFRESH_DIV=4 scan check.
   → an sequence 1110,1101,1011,0111,1110, each held 4 cycles. Reset asserted mid-scan → an=1111 and busy=0 on the next edge; scan resumes at 1110 after release.
